// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// if_stage: PC register, instruction-memory address and IF/ID pipeline register.
// Optional macro IF_MISALIGN_TRAP_EN: misaligned redirects trap instead of being
// silently aligned.  Revision: 1.0
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pc_sel,
  input  logic [31:0] i_alu_data,
  input  logic        i_stall,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc_id,
  output logic [31:0] o_pc4_id,
  output logic [31:0] o_inst_id,
  output logic        o_valid_id,
  output logic        o_misaligned
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_TRAP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc4_id_q, pc4_id_d;
  logic [31:0] inst_id_q, inst_id_d;
  logic        valid_id_q, valid_id_d;
  logic        mis_q, mis_d;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_id_d    = pc_id_q;
    pc4_id_d   = pc4_id_q;
    inst_id_d  = inst_id_q;
    valid_id_d = valid_id_q;
    mis_d      = mis_q;

    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (i_pc_sel) begin
          // The instruction fetched this cycle is wrong-path: squash it.
          pc_id_d    = 32'd0;
          pc4_id_d   = 32'd0;
          inst_id_d  = NOP_INST;
          valid_id_d = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
          if (i_alu_data[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = S_TRAP;
          end else begin
            pc_d = i_alu_data;
          end
`else
          pc_d = {i_alu_data[31:2], 2'b00};
`endif
        end else if (!i_stall) begin
          pc_d       = w_pc_plus4;
          pc_id_d    = pc_q;
          pc4_id_d   = w_pc_plus4;
          inst_id_d  = i_imem_rdata;
          valid_id_d = 1'b1;
        end
      end
      default: begin
        pc_id_d    = 32'd0;
        pc4_id_d   = 32'd0;
        inst_id_d  = NOP_INST;
        valid_id_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      pc_id_q    <= 32'd0;
      pc4_id_q   <= 32'd0;
      inst_id_q  <= NOP_INST;
      valid_id_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_id_q    <= pc_id_d;
      pc4_id_q   <= pc4_id_d;
      inst_id_q  <= inst_id_d;
      valid_id_q <= valid_id_d;
      mis_q      <= mis_d;
    end
  end

  assign o_imem_addr = pc_q;
  assign o_pc_id     = pc_id_q;
  assign o_pc4_id    = pc4_id_q;
  assign o_inst_id   = inst_id_q;
  assign o_valid_id  = valid_id_q;

`ifdef IF_MISALIGN_TRAP_EN
  assign o_misaligned = mis_q;
`else
  // Low target bits are discarded when the trap is compiled out.
  logic w_unused_lsbs;
  assign w_unused_lsbs = ^{i_alu_data[1:0], mis_q};
  assign o_misaligned  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// tb_if_stage: table-driven directed checks of if_stage plus hand sequences.
// Revision: 1.0
// ============================================================================
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        pc_sel;
  logic [31:0] alu_data;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_id;
  logic [31:0] pc4_id;
  logic [31:0] inst_id;
  logic        valid_id;
  logic        misaligned;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef IF_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_pc_sel    (pc_sel),
    .i_alu_data  (alu_data),
    .i_stall     (stall),
    .o_imem_addr (imem_addr),
    .i_imem_rdata(imem_rdata),
    .o_pc_id     (pc_id),
    .o_pc4_id    (pc4_id),
    .o_inst_id   (inst_id),
    .o_valid_id  (valid_id),
    .o_misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        pc_sel;
    logic        stall;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_mis;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input string nm, input logic r, input logic ps,
                         input logic st, input logic [31:0] alu, input logic [31:0] rd,
                         input logic [31:0] ea, input logic [31:0] ep, input logic [31:0] ep4,
                         input logic [31:0] ei, input logic ev, input logic em);
    vecs[i] = '{nm, r, ps, st, alu, rd, ea, ep, ep4, ei, ev, em};
  endtask

  task automatic check_outputs(input string nm, input logic [31:0] ea, input logic [31:0] ep,
                               input logic [31:0] ep4, input logic [31:0] ei,
                               input logic ev, input logic em);
    check({nm, ".addr"},  imem_addr, ea);
    check({nm, ".pc"},    pc_id,     ep);
    check({nm, ".pc4"},   pc4_id,    ep4);
    check({nm, ".inst"},  inst_id,   ei);
    check({nm, ".valid"}, {31'd0, valid_id},   {31'd0, ev});
    check({nm, ".mis"},   {31'd0, misaligned}, {31'd0, em});
  endtask

  initial begin
    logic [31:0] m_pc;
    logic [31:0] m_a;

    //      idx name          rst ps st alu           rdata          addr          pc            pc4           inst          v  m
    set_vec(0,  "rst0",        0, 0, 0, 32'h0,        32'h0,         32'h0,        32'h0,        32'h0,        32'h13,       0, 0);
    set_vec(1,  "rst1",        0, 1, 0, 32'h300,      32'h0,         32'h0,        32'h0,        32'h0,        32'h13,       0, 0);
    set_vec(2,  "boot",        1, 1, 0, 32'h200,      32'h0050_0093, 32'h0,        32'h0,        32'h0,        32'h13,       0, 0);
    set_vec(3,  "adv0",        1, 0, 0, 32'h0,        32'h0050_0093, 32'h4,        32'h0,        32'h4,        32'h0050_0093,1, 0);
    set_vec(4,  "adv4",        1, 0, 0, 32'h0,        32'h0010_0113, 32'h8,        32'h4,        32'h8,        32'h0010_0113,1, 0);
    set_vec(5,  "stall1",      1, 0, 1, 32'h0,        32'hDEAD_BEEF, 32'h8,        32'h4,        32'h8,        32'h0010_0113,1, 0);
    set_vec(6,  "stall2",      1, 0, 1, 32'h0,        32'hDEAD_BEEF, 32'h8,        32'h4,        32'h8,        32'h0010_0113,1, 0);
    set_vec(7,  "adv8",        1, 0, 0, 32'h0,        32'h0020_8193, 32'hC,        32'h8,        32'hC,        32'h0020_8193,1, 0);
    set_vec(8,  "redir_stall", 1, 1, 1, 32'h100,      32'h1111_1111, 32'h100,      32'h0,        32'h0,        32'h13,       0, 0);
    set_vec(9,  "adv100",      1, 0, 0, 32'h0,        32'h2222_2222, 32'h104,      32'h100,      32'h104,      32'h2222_2222,1, 0);
    set_vec(10, "redir_top",   1, 1, 0, 32'hFFFF_FFFC,32'h0,         32'hFFFF_FFFC,32'h0,        32'h0,        32'h13,       0, 0);
    set_vec(11, "wrap",        1, 0, 0, 32'h0,        32'h3333_3333, 32'h0,        32'hFFFF_FFFC,32'h0,        32'h3333_3333,1, 0);
    set_vec(12, "redir40",     1, 1, 0, 32'h40,       32'h0,         32'h40,       32'h0,        32'h0,        32'h13,       0, 0);
    if (TRAP_EN) begin
      set_vec(13, "mis_redir", 1, 1, 0, 32'h102,      32'h0,         32'h40,       32'h0,        32'h0,        32'h13,       0, 1);
      set_vec(14, "trap_adv",  1, 0, 0, 32'h0,        32'h5555_5555, 32'h40,       32'h0,        32'h0,        32'h13,       0, 1);
      set_vec(15, "trap_redir",1, 1, 0, 32'h200,      32'h0,         32'h40,       32'h0,        32'h0,        32'h13,       0, 1);
    end else begin
      set_vec(13, "mis_redir", 1, 1, 0, 32'h102,      32'h0,         32'h100,      32'h0,        32'h0,        32'h13,       0, 0);
      set_vec(14, "mis_adv",   1, 0, 0, 32'h0,        32'h5555_5555, 32'h104,      32'h100,      32'h104,      32'h5555_5555,1, 0);
      set_vec(15, "redir200",  1, 1, 0, 32'h203,      32'h0,         32'h200,      32'h0,        32'h0,        32'h13,       0, 0);
    end
    set_vec(16, "rst_again",   0, 1, 1, 32'h400,      32'h0,         32'h0,        32'h0,        32'h0,        32'h13,       0, 0);
    set_vec(17, "boot2",       1, 0, 0, 32'h0,        32'h6666_6666, 32'h0,        32'h0,        32'h0,        32'h13,       0, 0);

    rst_n = 1'b0; pc_sel = 1'b0; stall = 1'b0; alu_data = '0; imem_rdata = '0;

    for (int i = 0; i < NV; i++) begin
      rst_n      = vecs[i].rst_n;
      pc_sel     = vecs[i].pc_sel;
      stall      = vecs[i].stall;
      alu_data   = vecs[i].alu;
      imem_rdata = vecs[i].rdata;
      @(posedge clk);
      #1;
      check_outputs(vecs[i].name, vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_pc4,
                    vecs[i].e_inst, vecs[i].e_valid, vecs[i].e_mis);
    end

    // Advance chain after BOOT; imem model returns an address-derived word.
    pc_sel = 1'b0; stall = 1'b0;
    m_pc = 32'h0;
    for (int k = 0; k < 4; k++) begin
      m_a = imem_addr;
      check("chain.addr_pre", m_a, m_pc);
      imem_rdata = m_pc ^ 32'hA5A5_0000;
      @(posedge clk);
      #1;
      check_outputs("chain", m_pc + 32'd4, m_pc, m_pc + 32'd4,
                    m_pc ^ 32'hA5A5_0000, 1'b1, 1'b0);
      m_pc = m_pc + 32'd4;
    end

    // Stall then redirect in the following cycle: redirect must win immediately.
    stall = 1'b1; imem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    check_outputs("stall_hold", 32'h10, 32'hC, 32'h10, 32'hA5A5_000C, 1'b1, 1'b0);
    pc_sel = 1'b1; alu_data = 32'h0000_0800;
    @(posedge clk); #1;
    check_outputs("stall_redir", 32'h800, 32'h0, 32'h0, 32'h13, 1'b0, 1'b0);
    pc_sel = 1'b0; stall = 1'b0; imem_rdata = 32'h0880_0893;
    @(posedge clk); #1;
    check_outputs("after_redir", 32'h804, 32'h800, 32'h804, 32'h0880_0893, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
